// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared definitions for the demux_1x8 driver: channel count,
//               select width, the FIFO request record and the driver FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Number of demux outputs (a..h) and select-bus width.
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    // One queued request: target channel plus the data bit to steer there.
    localparam int REQ_W  = CH_W + 1;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic            data;
    } req_t;

    // Driver FSM encoding (3-bit, values fixed for debug visibility).
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOLD       = 3'd1,
        GAP        = 3'd2,
        SWEEP_HOLD = 3'd3,
        SWEEP_GAP  = 3'd4
    } drv_state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux_req_fifo
// Description : Synchronous request FIFO with first-word fall-through read.
//               rd_data always shows the head entry while empty is low, so the
//               consumer can use it in the same cycle it asserts pop.
//               Pushes while full and pops while empty are ignored.
//
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset (empties the FIFO)
//               push     - write wr_data this cycle (ignored when full)
//               wr_data  - entry to enqueue
//               pop      - retire the head entry (ignored when empty)
//               rd_data  - head entry
//               full     - occupancy == DEPTH
//               empty    - occupancy == 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux_req_fifo #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int                ADDR_W       = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   c_COUNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == c_COUNT_FULL);
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign rd_data   = r_mem[r_rd_ptr];

    // Storage is not reset: the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : demux_req_fifo
`default_nettype wire

// File: rtl/demux_1x8_driver.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8_driver
// Description : Upstream driver for demux_1x8. Buffers (channel, bit)
//               requests in a small FIFO and presents each one on i/s2/s1/s
//               for HOLD_CYCLES cycles followed by a one-cycle gap with i=0.
//               A sweep mode walks channels 0..7 with i=1, producing a
//               walking one across demux outputs a..h.
//
// Ports       : clk          - rising-edge clock
//               rst          - synchronous active-high reset
//               req_valid    - request present
//               req_ready    - FIFO not full
//               req_chan     - target channel 0..7 (0=a .. 7=h)
//               req_bit      - data bit to steer to the channel
//               sweep_start  - one-cycle pulse, honoured only in IDLE
//               busy         - FSM not idle or FIFO not empty
//               i            - demux data input (registered)
//               s, s1, s2    - demux select LSB..MSB (registered)
//               delivered_cnt- saturating count of completed holds
//                              (only with DEMUX_DRV_STATS_EN)
//
// Options     : `define DEMUX_DRV_STATS_EN adds the delivered_cnt port.
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x8_driver
    import demux_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,   // power of two, >= 2
    parameter int HOLD_CYCLES = 2,   // >= 1
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CH_W-1:0] req_chan,
    input  logic            req_bit,
    input  logic            sweep_start,
    output logic            busy,
    output logic            i,
    output logic            s,
    output logic            s1,
    output logic            s2
`ifdef DEMUX_DRV_STATS_EN
    ,
    output logic [CNT_W-1:0] delivered_cnt
`endif
);

    localparam int                HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CH_W-1:0]   c_LAST_CH   = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t w_fifo_wr;
    req_t w_head;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_pop;

    assign w_fifo_wr = '{chan: req_chan, data: req_bit};

    demux_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_valid),
        .wr_data (w_fifo_wr),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    drv_state_e       r_state;
    drv_state_e       w_next_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_next;
    logic [CH_W-1:0]  r_sweep_idx;
    logic [CH_W-1:0]  w_sweep_idx_next;
    logic             r_i;
    logic             w_i_next;
    logic [CH_W-1:0]  r_sel;
    logic [CH_W-1:0]  w_sel_next;
    logic             w_hold_done;   // a hold phase (normal or sweep) ends this cycle

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_sweep_idx <= '0;
            r_i         <= 1'b0;
            r_sel       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_hold_cnt  <= w_hold_cnt_next;
            r_sweep_idx <= w_sweep_idx_next;
            r_i         <= w_i_next;
            r_sel       <= w_sel_next;
        end
    end

    // Output registers are loaded with the value for the state being entered,
    // so i/s2/s1/s change exactly on the state transition edge. The select
    // lines are only ever reloaded when a new hold begins; during GAP and IDLE
    // they keep their last value so no other demux output sees a glitch.
    always_comb begin
        w_next_state     = r_state;
        w_hold_cnt_next  = r_hold_cnt;
        w_sweep_idx_next = r_sweep_idx;
        w_i_next         = r_i;
        w_sel_next       = r_sel;
        w_pop            = 1'b0;
        w_hold_done      = 1'b0;

        case (r_state)
            IDLE: begin
                w_i_next = 1'b0;
                // A sweep request wins over a pending FIFO entry; the entry
                // stays queued and is served once the sweep finishes.
                if (sweep_start) begin
                    w_next_state     = SWEEP_HOLD;
                    w_sweep_idx_next = '0;
                    w_hold_cnt_next  = '0;
                    w_sel_next       = '0;
                    w_i_next         = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_pop           = 1'b1;
                    w_next_state    = HOLD;
                    w_hold_cnt_next = '0;
                    w_sel_next      = w_head.chan;
                    w_i_next        = w_head.data;
                end
            end

            HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_next_state = GAP;
                    w_i_next     = 1'b0;
                    w_hold_done  = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end

            GAP: begin
                w_next_state = IDLE;
                w_i_next     = 1'b0;
            end

            SWEEP_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_next_state = SWEEP_GAP;
                    w_i_next     = 1'b0;
                    w_hold_done  = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end

            SWEEP_GAP: begin
                // The sweep stops after the last channel; the index never wraps.
                if (r_sweep_idx == c_LAST_CH) begin
                    w_next_state = IDLE;
                    w_i_next     = 1'b0;
                end else begin
                    w_next_state     = SWEEP_HOLD;
                    w_sweep_idx_next = r_sweep_idx + 1'b1;
                    w_hold_cnt_next  = '0;
                    w_sel_next       = r_sweep_idx + 1'b1;
                    w_i_next         = 1'b1;
                end
            end

            default: begin
                w_next_state = IDLE;
                w_i_next     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = !w_fifo_full;
    assign busy         = (r_state != IDLE) || !w_fifo_empty;
    assign i            = r_i;
    assign {s2, s1, s}  = r_sel;

`ifdef DEMUX_DRV_STATS_EN
    // Saturating delivery counter: sticks at all-ones rather than wrapping.
    logic [CNT_W-1:0] r_delivered_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_delivered_cnt <= '0;
        end else if (w_hold_done && (r_delivered_cnt != '1)) begin
            r_delivered_cnt <= r_delivered_cnt + 1'b1;
        end
    end

    assign delivered_cnt = r_delivered_cnt;
`else
    logic w_unused_hold_done;
    assign w_unused_hold_done = w_hold_done;
`endif

endmodule : demux_1x8_driver
`default_nettype wire

// File: tb/tb_demux_1x8_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x8_driver
// Description : Self-checking bench for demux_1x8_driver. A directed vector
//               table and hand-written sequences check fixed expectations;
//               in every cycle a frame-queue reference model (each served
//               request or sweep expands into a list of per-cycle output
//               frames) is compared against the DUT. Define
//               DEMUX_DRV_STATS_EN to also check delivered_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x8_driver;

    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_CYCLES = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_chan = 3'd0;
    logic       req_bit = 1'b0;
    logic       sweep_start = 1'b0;
    logic       busy;
    logic       i;
    logic       s;
    logic       s1;
    logic       s2;
`ifdef DEMUX_DRV_STATS_EN
    logic [CNT_W-1:0] delivered_cnt;
`endif

    always #5 clk = ~clk;

    demux_1x8_driver #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_chan    (req_chan),
        .req_bit     (req_bit),
        .sweep_start (sweep_start),
        .busy        (busy),
        .i           (i),
        .s           (s),
        .s1          (s1),
        .s2          (s2)
`ifdef DEMUX_DRV_STATS_EN
        ,
        .delivered_cnt (delivered_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending requests in a queue; whenever the driver is
    // free it expands the next job into per-cycle output frames.
    // ------------------------------------------------------------------
    typedef struct {
        logic       fi;
        logic [2:0] fsel;
        logic       dlv;   // this frame closes a hold -> one delivery
    } frame_t;

    frame_t     plan[$];
    logic [3:0] mq[$];
    logic       m_i   = 1'b0;
    logic [2:0] m_sel = 3'd0;
    int         m_cnt = 0;

    function automatic frame_t mkf(input logic fi, input logic [2:0] fsel, input logic dlv);
        frame_t f;
        f.fi = fi; f.fsel = fsel; f.dlv = dlv;
        return f;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [2:0] ch,
                              input logic b, input logic st);
        logic       can_push;
        logic [3:0] e;
        frame_t     f;
        if (r) begin
            plan.delete();
            mq.delete();
            m_i = 1'b0; m_sel = 3'd0; m_cnt = 0;
            return;
        end
        can_push = (mq.size() < FIFO_DEPTH);
        if (plan.size() == 0) begin
            if (st) begin
                for (int c = 0; c < 8; c++) begin
                    for (int h = 0; h < HOLD_CYCLES; h++) plan.push_back(mkf(1'b1, 3'(c), 1'b0));
                    plan.push_back(mkf(1'b0, 3'(c), 1'b1));
                end
                plan.push_back(mkf(1'b0, 3'd7, 1'b0));
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                for (int h = 0; h < HOLD_CYCLES; h++) plan.push_back(mkf(e[0], e[3:1], 1'b0));
                plan.push_back(mkf(1'b0, e[3:1], 1'b1));
                plan.push_back(mkf(1'b0, e[3:1], 1'b0));
            end
        end
        if (plan.size() > 0) begin
            f = plan.pop_front();
            m_i = f.fi;
            m_sel = f.fsel;
            if (f.dlv && m_cnt < CNT_MAX) m_cnt++;
        end
        if (v && can_push) mq.push_back({ch, b});
    endtask

    task automatic model_check();
        check("model i", 32'(i), 32'(m_i));
        check("model sel", 32'({s2, s1, s}), 32'(m_sel));
        check("model req_ready", 32'(req_ready), (mq.size() < FIFO_DEPTH) ? 1 : 0);
        check("model busy", 32'(busy), (plan.size() > 0 || mq.size() > 0) ? 1 : 0);
`ifdef DEMUX_DRV_STATS_EN
        check("model delivered_cnt", 32'(delivered_cnt), 32'(m_cnt));
`endif
    endtask

    // Drive inputs, clock once, advance the model, sample on the falling edge.
    task automatic tick(input logic r, input logic v, input logic [2:0] ch,
                        input logic b, input logic st);
        rst = r; req_valid = v; req_chan = ch; req_bit = b; sweep_start = st;
        @(posedge clk);
        model_step(r, v, ch, b, st);
        @(negedge clk);
        model_check();
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int budget = 100;
        while (busy && budget > 0) begin
            idle_tick();
            budget--;
        end
        check(name, 32'(busy), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, outputs after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] chan;
        logic       data;
        logic       start;
        logic       exp_i;
        logic [2:0] exp_sel;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic r, input logic v, input logic [2:0] ch,
                                 input logic b, input logic st, input logic ei,
                                 input logic [2:0] es, input logic er, input logic eb);
        vec_t t;
        t.rst = r; t.valid = v; t.chan = ch; t.data = b; t.start = st;
        t.exp_i = ei; t.exp_sel = es; t.exp_ready = er; t.exp_busy = eb;
        return t;
    endfunction

    logic [3:0] entries [8];
    int         acc;
    logic       rdy;
    logic [7:0] dmx;

    initial begin : main
        // Reset state, then a single request chan=6 bit=1 (HOLD_CYCLES=2).
        vecs.push_back(mkv(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 6, 1, 0,  0, 0, 1, 1)); // accepted, not yet driven
        vecs.push_back(mkv(0, 0, 0, 0, 0,  1, 6, 1, 1)); // popped: hold cycle 1
        vecs.push_back(mkv(0, 0, 0, 0, 0,  1, 6, 1, 1)); // hold cycle 2
        vecs.push_back(mkv(0, 0, 0, 0, 0,  0, 6, 1, 1)); // gap, select kept
        vecs.push_back(mkv(0, 0, 0, 0, 0,  0, 6, 1, 0)); // idle
        vecs.push_back(mkv(0, 0, 0, 0, 0,  0, 6, 1, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            tick(vecs[k].rst, vecs[k].valid, vecs[k].chan, vecs[k].data, vecs[k].start);
            check($sformatf("vec[%0d] i", k), 32'(i), 32'(vecs[k].exp_i));
            check($sformatf("vec[%0d] sel", k), 32'({s2, s1, s}), 32'(vecs[k].exp_sel));
            check($sformatf("vec[%0d] req_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
            check($sformatf("vec[%0d] busy", k), 32'(busy), 32'(vecs[k].exp_busy));
        end

        // Reset mid-hold with a second request still queued.
        tick(0, 1, 3'd5, 1, 0);
        tick(0, 1, 3'd3, 0, 0);
        check("t1 mid-hold i", 32'(i), 1);
        check("t1 mid-hold sel", 32'({s2, s1, s}), 5);
        tick(1, 0, 0, 0, 0);
        check("t1 reset i", 32'(i), 0);
        check("t1 reset sel", 32'({s2, s1, s}), 0);
        check("t1 reset req_ready", 32'(req_ready), 1);
        check("t1 reset busy", 32'(busy), 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            idle_tick();
            check("t1 no replay i", 32'(i), 0);
            check("t1 no replay sel", 32'({s2, s1, s}), 0);
        end

        // Back-pressure: FIFO fills during a sweep, drains in push order.
        entries[0] = {3'd3, 1'b1}; entries[1] = {3'd1, 1'b0};
        entries[2] = {3'd6, 1'b1}; entries[3] = {3'd4, 1'b1};
        entries[4] = {3'd2, 1'b1}; entries[5] = {3'd7, 1'b1};
        entries[6] = {3'd0, 1'b1}; entries[7] = {3'd5, 1'b1};
        tick(0, 0, 0, 0, 1);
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            rdy = req_ready;
            tick(0, 1, entries[acc][3:1], entries[acc][0], 0);
            if (rdy) acc++;
        end
        check("t3 accepted count", 32'(acc), 4);
        check("t3 ready low when full", 32'(req_ready), 0);
        begin : t3_wait
            int budget = 40;
            while (!req_ready && budget > 0) begin
                idle_tick();
                budget--;
            end
        end
        check("t3 ready returns", 32'(req_ready), 1);
        check("t3 first entry sel", 32'({s2, s1, s}), 3);
        check("t3 first entry i", 32'(i), 1);
        wait_idle("t3 drained");

        // Sweep with a request already queued; sweep goes first.
        tick(0, 1, 3'd2, 1, 0);
        tick(0, 0, 0, 0, 1);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) idle_tick();
            dmx = {8{i}} & (8'b1 << {s2, s1, s});
            check($sformatf("t4 sweep[%0d] sel", k), 32'({s2, s1, s}), k / 3);
            check($sformatf("t4 sweep[%0d] i", k), 32'(i), (k % 3 != 2) ? 1 : 0);
            check($sformatf("t4 sweep[%0d] demux", k), 32'(dmx), (k % 3 != 2) ? (1 << (k / 3)) : 0);
        end
        idle_tick();
        check("t4 post-sweep i", 32'(i), 0);
        check("t4 post-sweep busy", 32'(busy), 1);
        idle_tick();
        check("t4 queued req sel", 32'({s2, s1, s}), 2);
        check("t4 queued req i", 32'(i), 1);
        wait_idle("t4 drained");

        // sweep_start during HOLD is ignored.
        tick(0, 1, 3'd4, 1, 0);
        idle_tick();
        tick(0, 0, 0, 0, 1);
        check("t5 still holding", 32'(i), 1);
        idle_tick();
        idle_tick();
        check("t5 back to idle busy", 32'(busy), 0);
        for (int k = 0; k < 4; k++) begin
            idle_tick();
            check("t5 no sweep i", 32'(i), 0);
            check("t5 no sweep busy", 32'(busy), 0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 1'($urandom),
                 3'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        tick(1, 0, 0, 0, 0);

`ifdef DEMUX_DRV_STATS_EN
        // 20 deliveries into a 4-bit counter: saturates at 15.
        check("t6 cnt after reset", 32'(delivered_cnt), 0);
        acc = 0;
        begin : t6_push
            int budget = 300;
            while (acc < 20 && budget > 0) begin
                rdy = req_ready;
                tick(0, 1, 3'(acc), 1, 0);
                if (rdy) acc++;
                budget--;
            end
        end
        check("t6 pushed", 32'(acc), 20);
        wait_idle("t6 drained");
        check("t6 saturated cnt", 32'(delivered_cnt), 15);
        for (int k = 0; k < 5; k++) begin
            idle_tick();
            check("t6 cnt holds", 32'(delivered_cnt), 15);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_demux_1x8_driver
`default_nettype wire
